// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared types and constants for the XIFU execute stage.
//   fir_xifu_id2ex_t      : decoded load/store op handed from ID to EX
//   fir_xifu_ex2wb_t      : completion record handed from EX to WB
//   fir_xifu_ex_state_e   : EX stage FSM state encoding
//   sext_off()            : sign-extends the 12-bit offset to the address width
package fir_xifu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned OFF_W = 12;
    localparam int unsigned BE_W  = XLEN / 8;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              store;
        logic [XLEN-1:0]   base;
        logic [OFF_W-1:0]  offset;
        logic [XLEN-1:0]   wdata;
    } fir_xifu_id2ex_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              store;
        logic              err;
        logic [XLEN-1:0]   rdata;
    } fir_xifu_ex2wb_t;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_REQ  = 2'd1,
        EX_WAIT = 2'd2
    } fir_xifu_ex_state_e;

    // Sign-extend a signed 12-bit immediate offset to a full address word.
    function automatic logic [XLEN-1:0] sext_off(input logic [OFF_W-1:0] off);
        return {{(XLEN-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fir_xifu_if.sv
// fir_xifu_if: word-wide memory request/response bus between the EX stage
// and the data memory.
//   valid/ready        : request handshake (master -> slave, slave -> master)
//   addr/we/be/wdata/id: request payload, driven by the master
//   rvalid/rdata/err   : response, driven by the slave
// Modports: master (EX stage), slave (memory or its model).
interface fir_xifu_if;
    import fir_xifu_pkg::*;

    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
    logic [ID_W-1:0]   id;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;
    logic              err;

    modport master (
        output valid, addr, we, be, wdata, id,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, addr, we, be, wdata, id,
        output ready, rvalid, rdata, err
    );

endinterface

// File: rtl/fir_xifu_agu.sv
// fir_xifu_agu: combinational address generation for the EX stage.
//   base_i       : 32-bit base register value
//   offset_i     : signed 12-bit immediate offset
//   addr_o       : base + sign-extended offset, wrapping modulo 2^32
//   misaligned_o : 1 when addr_o is not word aligned
module fir_xifu_agu
    import fir_xifu_pkg::*;
(
    input  logic [XLEN-1:0]  base_i,
    input  logic [OFF_W-1:0] offset_i,
    output logic [XLEN-1:0]  addr_o,
    output logic             misaligned_o
);

    // Carry out of bit 31 is simply dropped: wrap-around is intended.
    assign addr_o       = base_i + sext_off(offset_i);
    assign misaligned_o = |addr_o[1:0];

endmodule

// File: rtl/fir_xifu_ex.sv
// fir_xifu_ex: execute stage of the XIFU load/store path. Accepts one decoded
// op at a time, issues a single word access on the memory bus and returns a
// completion record to write-back.
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   id2ex_i       : decoded op from ID
//   ex_ready_o    : EX is idle and will accept id2ex_i this cycle
//   kill_i/kill_id_i : squash request for the op with the given id
//   mem           : memory bus (master side)
//   ex2wb_o       : one-cycle completion pulse plus held result fields
module fir_xifu_ex
    import fir_xifu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  fir_xifu_id2ex_t   id2ex_i,
    output logic              ex_ready_o,
    input  logic              kill_i,
    input  logic [ID_W-1:0]   kill_id_i,
    fir_xifu_if.master        mem,
    output fir_xifu_ex2wb_t   ex2wb_o
);

    fir_xifu_ex_state_e state_q, state_d;
    logic [XLEN-1:0]    addr_q,  addr_d;
    logic               we_q,    we_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [ID_W-1:0]    id_q,    id_d;
    // Set once the in-flight op has been killed after its request was
    // accepted: the access must still finish, but no result is reported.
    logic               drop_q,  drop_d;
    fir_xifu_ex2wb_t    wb_q,    wb_d;

    logic [XLEN-1:0]    agu_addr;
    logic               agu_misaligned;
    logic               kill_match;

    fir_xifu_agu u_agu (
        .base_i       (id2ex_i.base),
        .offset_i     (id2ex_i.offset),
        .addr_o       (agu_addr),
        .misaligned_o (agu_misaligned)
    );

    // Kills only ever target the op currently held in EX.
    assign kill_match = kill_i && (kill_id_i == id_q);

    // Next-state and next-register computation for the EX FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        drop_d      = drop_q;
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;

        case (state_q)
            EX_IDLE: begin
                if (id2ex_i.valid) begin
                    if (agu_misaligned) begin
                        // Rejected without touching memory; report an error.
                        wb_d.valid = 1'b1;
                        wb_d.id    = id2ex_i.id;
                        wb_d.store = id2ex_i.store;
                        wb_d.err   = 1'b1;
                        wb_d.rdata = {XLEN{1'b0}};
                    end else begin
                        addr_d  = agu_addr;
                        we_d    = id2ex_i.store;
                        wdata_d = id2ex_i.wdata;
                        id_d    = id2ex_i.id;
                        drop_d  = 1'b0;
                        state_d = EX_REQ;
                    end
                end else begin
                    state_d = EX_IDLE;
                end
            end

            EX_REQ: begin
                if (mem.ready) begin
                    // Request is accepted: a kill now cannot recall it.
                    drop_d  = kill_match;
                    state_d = EX_WAIT;
                end else if (kill_match) begin
                    state_d = EX_IDLE;
                end else begin
                    state_d = EX_REQ;
                end
            end

            EX_WAIT: begin
                if (mem.rvalid) begin
                    state_d = EX_IDLE;
                    if (!(drop_q || kill_match)) begin
                        wb_d.valid = 1'b1;
                        wb_d.id    = id_q;
                        wb_d.store = we_q;
                        wb_d.err   = mem.err;
                        wb_d.rdata = we_q ? {XLEN{1'b0}} : mem.rdata;
                    end else begin
                        wb_d.valid = 1'b0;
                    end
                end else begin
                    drop_d = drop_q | kill_match;
                end
            end

            default: begin
                state_d = EX_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EX_IDLE;
            addr_q  <= {XLEN{1'b0}};
            we_q    <= 1'b0;
            wdata_q <= {XLEN{1'b0}};
            id_q    <= {ID_W{1'b0}};
            drop_q  <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            drop_q  <= drop_d;
            wb_q    <= wb_d;
        end
    end

    assign ex_ready_o = (state_q == EX_IDLE);
    assign mem.valid  = (state_q == EX_REQ);
    assign mem.addr   = addr_q;
    assign mem.we     = we_q;
    assign mem.be     = {BE_W{1'b1}};
    assign mem.wdata  = wdata_q;
    assign mem.id     = id_q;
    assign ex2wb_o    = wb_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// tb_fir_xifu_ex: directed and randomized checks of fir_xifu_ex against a
// transaction-level expectation built from the address/kill/completion rules.
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    fir_xifu_id2ex_t id2ex;
    logic            ex_ready;
    logic            kill_i;
    logic [3:0]      kill_id;
    fir_xifu_ex2wb_t ex2wb;
    fir_xifu_ex2wb_t exp_wb;

    int tests = 0;
    int fails = 0;

    fir_xifu_if mem_bus ();

    fir_xifu_ex dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .id2ex_i    (id2ex),
        .ex_ready_o (ex_ready),
        .kill_i     (kill_i),
        .kill_id_i  (kill_id),
        .mem        (mem_bus),
        .ex2wb_o    (ex2wb)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic chk_wb_fields;
        chk("wb_id",    {28'd0, ex2wb.id},    {28'd0, exp_wb.id});
        chk("wb_store", {31'd0, ex2wb.store}, {31'd0, exp_wb.store});
        chk("wb_err",   {31'd0, ex2wb.err},   {31'd0, exp_wb.err});
        chk("wb_rdata", ex2wb.rdata,          exp_wb.rdata);
    endtask

    task automatic chk_req(input logic [31:0] a, input logic st, input logic [31:0] wd, input logic [3:0] opid);
        chk("req_valid", {31'd0, mem_bus.valid}, 32'd1);
        chk("req_addr",  mem_bus.addr, a);
        chk("req_we",    {31'd0, mem_bus.we}, {31'd0, st});
        if (st) chk("req_wdata", mem_bus.wdata, wd);
        chk("req_id",    {28'd0, mem_bus.id}, {28'd0, opid});
        chk("req_be",    {28'd0, mem_bus.be}, 32'hF);
        chk("req_ready", {31'd0, ex_ready}, 32'd0);
    endtask

    // kmode: 0 none, 1 kill before handshake, 2 kill in handshake cycle,
    // 3 kill in WAIT, 4 non-matching kill in REQ, 5 matching kill while IDLE.
    task automatic do_op(input logic st, input logic [3:0] opid, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd, input int rdly_in,
                         input int vdly, input logic [31:0] rd, input logic er,
                         input int kmode, input logic noise);
        logic signed [11:0] soff;
        logic [31:0] exp_addr;
        int rdly;
        int ncyc;
        bit pulse;
        soff     = off;
        exp_addr = base + 32'(soff);
        rdly     = (kmode == 1 && rdly_in == 0) ? 1 : rdly_in;
        ncyc     = 0;

        chk("idle_ready", {31'd0, ex_ready}, 32'd1);
        id2ex = '{valid: 1'b1, id: opid, store: st, base: base, offset: off, wdata: wd};
        if (kmode == 5) begin kill_i = 1'b1; kill_id = opid; end
        tick; ncyc++;
        id2ex.valid = 1'b0;
        kill_i = 1'b0;

        if (exp_addr[1:0] != 2'b00) begin
            exp_wb = '{valid: 1'b1, id: opid, store: st, err: 1'b1, rdata: 32'd0};
            chk("mis_noreq",  {31'd0, mem_bus.valid}, 32'd0);
            chk("mis_pulse",  {31'd0, ex2wb.valid}, 32'd1);
            chk("mis_ready",  {31'd0, ex_ready}, 32'd1);
            chk_wb_fields();
            tick;
            chk("mis_onepulse", {31'd0, ex2wb.valid}, 32'd0);
            chk("mis_noreq2",   {31'd0, mem_bus.valid}, 32'd0);
            return;
        end

        for (int k = 0; k < rdly; k++) begin
            chk_req(exp_addr, st, wd, opid);
            if (kmode == 1) begin
                kill_i = 1'b1; kill_id = opid;
                tick;
                kill_i = 1'b0;
                chk("kreq_valid", {31'd0, mem_bus.valid}, 32'd0);
                chk("kreq_ready", {31'd0, ex_ready}, 32'd1);
                chk("kreq_nopulse", {31'd0, ex2wb.valid}, 32'd0);
                tick;
                chk("kreq_nopulse2", {31'd0, ex2wb.valid}, 32'd0);
                return;
            end
            if (kmode == 4) begin kill_i = 1'b1; kill_id = opid ^ 4'h1; end
            mem_bus.rvalid = noise ? 1'($urandom_range(1)) : 1'b0;
            mem_bus.rdata  = $urandom;
            tick; ncyc++;
            kill_i = 1'b0;
            mem_bus.rvalid = 1'b0;
        end

        chk_req(exp_addr, st, wd, opid);
        mem_bus.ready = 1'b1;
        if (kmode == 2) begin kill_i = 1'b1; kill_id = opid; end
        if (kmode == 4) begin kill_i = 1'b1; kill_id = opid ^ 4'h1; end
        tick; ncyc++;
        mem_bus.ready = 1'b0;
        kill_i = 1'b0;
        chk("wait_novalid", {31'd0, mem_bus.valid}, 32'd0);
        chk("wait_ready",   {31'd0, ex_ready}, 32'd0);
        chk("wait_nopulse", {31'd0, ex2wb.valid}, 32'd0);

        for (int k = 0; k < vdly; k++) begin
            if (kmode == 3 && k == 0) begin kill_i = 1'b1; kill_id = opid; end
            tick; ncyc++;
            kill_i = 1'b0;
            chk("wait_hold", {31'd0, ex2wb.valid}, 32'd0);
        end
        if (kmode == 3 && vdly == 0) begin kill_i = 1'b1; kill_id = opid; end
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = rd;
        mem_bus.err    = er;
        tick; ncyc++;
        mem_bus.rvalid = 1'b0;
        mem_bus.err    = 1'b0;
        kill_i = 1'b0;

        pulse = !(kmode == 1 || kmode == 2 || kmode == 3);
        if (pulse) begin
            exp_wb = '{valid: 1'b1, id: opid, store: st, err: er, rdata: st ? 32'd0 : rd};
            chk("latency", ncyc, 3 + rdly + vdly);
        end
        chk("done_pulse", {31'd0, ex2wb.valid}, {31'd0, pulse});
        chk_wb_fields();
        chk("done_ready", {31'd0, ex_ready}, 32'd1);
        tick;
        chk("done_onepulse", {31'd0, ex2wb.valid}, 32'd0);
        chk_wb_fields();
    endtask

    initial begin
        rst_ni = 1'b0;
        id2ex = '0;
        kill_i = 1'b0;
        kill_id = 4'd0;
        mem_bus.ready = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata = 32'd0;
        mem_bus.err = 1'b0;
        exp_wb = '0;
        tick;
        tick;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_valid", {31'd0, mem_bus.valid}, 32'd0);
        chk("rst_we",    {31'd0, mem_bus.we}, 32'd0);
        chk("rst_addr",  mem_bus.addr, 32'd0);
        chk("rst_wdata", mem_bus.wdata, 32'd0);
        chk("rst_id",    {28'd0, mem_bus.id}, 32'd0);
        chk("rst_wb",    {31'd0, ex2wb.valid}, 32'd0);
        chk_wb_fields();
        rst_ni = 1'b1;
        tick;

        // Basic load with immediate memory response.
        do_op(1'b0, 4'd1, 32'h0000_1000, 12'h004, 32'd0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        // Store with negative offset and a five-cycle ready stall.
        do_op(1'b1, 4'd2, 32'h0000_2000, 12'hFFC, 32'h1234_5678, 5, 0, 32'hAAAA_5555, 1'b0, 0, 1'b0);
        // Address wrap-around.
        do_op(1'b0, 4'd5, 32'hFFFF_FFFC, 12'h008, 32'd0, 0, 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
        // Misaligned access.
        do_op(1'b0, 4'd6, 32'h0000_1001, 12'h000, 32'd0, 0, 0, 32'd0, 1'b0, 0, 1'b0);
        // Kill before handshake, then kill in WAIT.
        do_op(1'b0, 4'd3, 32'h0000_3000, 12'h010, 32'd0, 2, 0, 32'h1111_2222, 1'b0, 1, 1'b0);
        do_op(1'b0, 4'd3, 32'h0000_3000, 12'h010, 32'd0, 0, 2, 32'h3333_4444, 1'b0, 3, 1'b0);
        // Kill in handshake cycle, non-matching kill, kill while idle, memory error.
        do_op(1'b0, 4'd7, 32'h0000_4000, 12'h7FC, 32'd0, 1, 0, 32'h5555_6666, 1'b0, 2, 1'b0);
        do_op(1'b1, 4'd8, 32'h0000_5000, 12'h800, 32'h0F0F_0F0F, 2, 1, 32'h7777_8888, 1'b0, 4, 1'b1);
        do_op(1'b0, 4'd9, 32'h0000_6000, 12'h000, 32'd0, 0, 0, 32'h9999_AAAA, 1'b1, 5, 1'b0);

        // Randomized ops.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] rb;
            rb = $urandom;
            if ($urandom_range(3) != 0) rb[1:0] = 2'b00;
            do_op(1'($urandom_range(1)), 4'($urandom_range(15)), rb, 12'($urandom_range(4095)),
                  $urandom, $urandom_range(3), $urandom_range(3), $urandom, 1'($urandom_range(1)),
                  $urandom_range(5), 1'($urandom_range(1)));
        end

        // Reset while waiting for the response; a late response must be ignored.
        id2ex = '{valid: 1'b1, id: 4'd4, store: 1'b0, base: 32'h0000_8000, offset: 12'h020, wdata: 32'd0};
        tick;
        id2ex.valid = 1'b0;
        mem_bus.ready = 1'b1;
        tick;
        mem_bus.ready = 1'b0;
        chk("rw_inwait", {31'd0, ex_ready}, 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("rw_ready",  {31'd0, ex_ready}, 32'd1);
        chk("rw_addr",   mem_bus.addr, 32'd0);
        chk("rw_valid",  {31'd0, mem_bus.valid}, 32'd0);
        tick;
        rst_ni = 1'b1;
        exp_wb = '0;
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata = 32'hCAFE_F00D;
        tick;
        mem_bus.rvalid = 1'b0;
        chk("rw_nopulse", {31'd0, ex2wb.valid}, 32'd0);
        chk_wb_fields();
        chk("rw_ready2", {31'd0, ex_ready}, 32'd1);
        chk("rw_we",     {31'd0, mem_bus.we}, 32'd0);
        chk("rw_id",     {28'd0, mem_bus.id}, 32'd0);
        tick;
        chk("rw_nopulse2", {31'd0, ex2wb.valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
